// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encodings and default bus widths for the IF/MEM memory arbiter.
package mem_port_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2
   } arb_state_t;

   function automatic arb_state_t busy_state(input logic is_d);
      return is_d ? ARB_BUSY_D : ARB_BUSY_I;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and memory port of the unified-memory arbiter.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              bus_err;

   // slave: the arbiter itself; master: the pipeline stages plus the memory model
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

endinterface

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// bus_watchdog: counts stalled busy cycles and flags expiry on the TIMEOUT-th one.
module bus_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] wd_cnt;

   assign expire = wd_cnt == LAST;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wd_cnt <= '0;
      else if (clear) wd_cnt <= '0;
      else if (enable && !expire) wd_cnt <= wd_cnt + 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data, data first with fetch anti-starvation.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input logic clk,
   input logic rst,
   mem_port_arbiter_if.slave bus
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

   arb_state_t        state;
   logic [SW-1:0]     starve_cnt;
   logic              idle;
   logic              expire;
   logic              done;
   logic              grant_d;
   logic              grant_i;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   assign idle      = state == ARB_IDLE;
   assign grant_d   = idle && bus.d_req && !(bus.if_req && starve_cnt == S_MAX);
   assign grant_i   = idle && !grant_d && bus.if_req;
   assign win_addr  = grant_d ? bus.d_addr : bus.if_addr;
   assign win_wdata = grant_d ? bus.d_wdata : '0;

   // an ack in the expiry cycle completes normally; only a silent expiry is an error
   assign done         = !idle && (bus.mem_ack || expire);
   assign bus.if_ready = done && state == ARB_BUSY_I;
   assign bus.d_ready  = done && state == ARB_BUSY_D;
   assign bus.if_rdata = (bus.if_ready && bus.mem_ack) ? bus.mem_rdata : '0;
   assign bus.d_rdata  = (bus.d_ready && bus.mem_ack) ? bus.mem_rdata : '0;

   bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk   (clk),
      .rst   (rst),
      .clear (idle),
      .enable(!idle && !bus.mem_ack),
      .expire(expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ARB_IDLE;
         starve_cnt    <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.bus_err   <= 1'b0;
      end else if (grant_d || grant_i) begin
         state         <= busy_state(grant_d);
         bus.mem_req   <= 1'b1;
         bus.mem_we    <= grant_d && bus.d_we;
         bus.mem_addr  <= win_addr;
         bus.mem_wdata <= win_wdata;
         // a data win only ever counts up while starve_cnt is below S_MAX, so no wrap
         starve_cnt    <= (grant_d && bus.if_req) ? starve_cnt + 1'b1 : '0;
      end else if (done) begin
         state       <= ARB_IDLE;
         bus.mem_req <= 1'b0;
         if (!bus.mem_ack) bus.bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic, checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SMAX = 4;
   localparam int TOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TOUT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference: which access is in flight, how long it has waited, how many data wins in a row IF has sat through
   int          m_owner = 0;
   int          m_wait = 0;
   int          m_streak = 0;
   bit          m_err = 0;
   bit          m_we = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;

   always @(negedge clk) begin
      if (rst) begin
         m_owner  = 0;
         m_wait   = 0;
         m_streak = 0;
         m_err    = 0;
      end else begin
         automatic bit ack = bus.mem_ack;
         automatic bit fin = m_owner != 0 && (ack || m_wait == TOUT - 1);
         automatic logic [DW-1:0] rd = ack ? bus.mem_rdata : '0;
         chk("mdl_mem_req", bus.mem_req, m_owner != 0);
         if (m_owner != 0) begin
            chk("mdl_mem_we", bus.mem_we, m_we);
            chk("mdl_mem_addr", bus.mem_addr, m_addr);
            chk("mdl_mem_wdata", bus.mem_wdata, m_wdata);
         end
         chk("mdl_if_ready", bus.if_ready, fin && m_owner == 1);
         chk("mdl_d_ready", bus.d_ready, fin && m_owner == 2);
         if (fin && m_owner == 1) chk("mdl_if_rdata", bus.if_rdata, rd);
         if (fin && m_owner == 2) chk("mdl_d_rdata", bus.d_rdata, rd);
         chk("mdl_bus_err", bus.bus_err, m_err);
         if (m_owner != 0) begin
            if (fin) begin
               if (!ack) m_err = 1;
               m_owner = 0;
            end else m_wait++;
         end else if (bus.d_req && !(bus.if_req && m_streak == SMAX)) begin
            m_owner  = 2;
            m_wait   = 0;
            m_we     = bus.d_we;
            m_addr   = bus.d_addr;
            m_wdata  = bus.d_wdata;
            m_streak = bus.if_req ? m_streak + 1 : 0;
         end else if (bus.if_req) begin
            m_owner  = 1;
            m_wait   = 0;
            m_we     = 0;
            m_addr   = bus.if_addr;
            m_wdata  = '0;
            m_streak = 0;
         end
      end
   end

   task automatic wait_rdy(input bit is_d, output bit ok);
      ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         ok = is_d ? bus.d_ready : bus.if_ready;
      end
      if (!ok) chk("ready_timeout", 0, 1);
   endtask

   initial begin
      bit ok;
      bit if_done;
      bit d_done;
      bit no_ack;
      int nb;
      int n;
      logic [9:0] seq;
      bus.if_req = 0; bus.if_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0;
      @(negedge clk);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_bus_err", bus.bus_err, 0);
      chk("rst_ready", {bus.if_ready, bus.d_ready}, 0);
      cyc();
      rst = 0;

      // fetch only, three wait cycles
      cyc(); bus.if_req = 1; bus.if_addr = 32'h40;
      cyc();
      @(negedge clk);
      chk("t1_mem_req", bus.mem_req, 1);
      chk("t1_mem_addr", bus.mem_addr, 32'h40);
      chk("t1_mem_we", bus.mem_we, 0);
      cyc(); cyc();
      cyc(); bus.mem_ack = 1; bus.mem_rdata = 32'h2008_0005;
      @(negedge clk);
      chk("t1_if_ready", bus.if_ready, 1);
      chk("t1_if_rdata", bus.if_rdata, 32'h2008_0005);
      cyc(); bus.if_req = 0; bus.mem_ack = 0;
      @(negedge clk);
      chk("t1_mem_req_drop", bus.mem_req, 0);

      // simultaneous requests: store wins, fetch follows
      cyc(); bus.if_req = 1; bus.if_addr = 32'h44;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
      cyc(); bus.mem_ack = 1; bus.mem_rdata = 32'h0;
      @(negedge clk);
      chk("t2_mem_we", bus.mem_we, 1);
      chk("t2_mem_addr", bus.mem_addr, 32'h100);
      chk("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("t2_d_ready", bus.d_ready, 1);
      chk("t2_if_ready", bus.if_ready, 0);
      cyc(); bus.d_req = 0; bus.d_we = 0; bus.mem_ack = 0;
      cyc(); bus.mem_ack = 1; bus.mem_rdata = 32'h1234;
      @(negedge clk);
      chk("t2_i_addr", bus.mem_addr, 32'h44);
      chk("t2_i_ready", bus.if_ready, 1);
      cyc(); bus.if_req = 0; bus.mem_ack = 0;

      // starvation bound with zero-wait memory
      cyc(); bus.if_req = 1; bus.if_addr = 32'h80;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h180; bus.mem_ack = 1; bus.mem_rdata = 32'h11;
      seq = '0; n = 0;
      for (int k = 0; k < 40 && n < 10; k++) begin
         @(negedge clk);
         if (bus.if_ready || bus.d_ready) begin
            seq = {seq[8:0], bus.if_ready};
            n++;
         end
      end
      chk("t3_grant_count", n, 10);
      chk("t3_grant_order", seq, 10'b0000100001);
      cyc(); bus.if_req = 0; bus.d_req = 0; bus.mem_ack = 0;

      // watchdog abort, then error stays sticky
      cyc(); bus.d_req = 1; bus.d_addr = 32'h200; bus.mem_rdata = 32'h1234_5678;
      nb = 0; ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (bus.mem_req) nb++;
         ok = bus.d_ready;
      end
      chk("t4_busy_cycles", nb, 16);
      chk("t4_d_rdata", bus.d_rdata, 0);
      cyc(); bus.d_req = 0;
      @(negedge clk);
      chk("t4_bus_err", bus.bus_err, 1);
      cyc(); bus.if_req = 1; bus.if_addr = 32'h48; bus.mem_ack = 1; bus.mem_rdata = 32'h55;
      wait_rdy(0, ok);
      chk("t4_good_rdata", bus.if_rdata, 32'h55);
      cyc(); bus.if_req = 0; bus.mem_ack = 0;
      @(negedge clk);
      chk("t4_err_sticky", bus.bus_err, 1);

      // asynchronous reset in the middle of a data access
      cyc(); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h300; bus.d_wdata = 32'h1;
      cyc();
      #1 chk("t5_pre_req", bus.mem_req, 1);
      rst = 1;
      #1 chk("t5_async_req", bus.mem_req, 0);
      chk("t5_async_err", bus.bus_err, 0);
      @(negedge clk);
      chk("t5_no_ready", bus.d_ready, 0);
      cyc(); rst = 0; bus.d_req = 0; bus.d_we = 0;
      @(negedge clk);
      chk("t5_idle", bus.mem_req, 0);

      // ack on the final watchdog cycle completes normally
      cyc(); bus.d_req = 1; bus.d_addr = 32'h400; bus.mem_rdata = 32'hCAFE_F00D;
      repeat (16) cyc();
      bus.mem_ack = 1;
      @(negedge clk);
      chk("t6_d_ready", bus.d_ready, 1);
      chk("t6_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
      cyc(); bus.d_req = 0; bus.mem_ack = 0;
      @(negedge clk);
      chk("t6_no_err", bus.bus_err, 0);

      // random traffic that obeys the hold-until-ready protocol
      if_done = 0; d_done = 0; no_ack = 0;
      for (int c = 0; c < 4000; c++) begin
         cyc();
         if (if_done || !bus.if_req) begin
            bus.if_req = (if_done ? $urandom_range(0, 1) : $urandom_range(0, 2) == 0);
            bus.if_addr = $urandom;
         end
         if (d_done || !bus.d_req) begin
            bus.d_req = (d_done ? $urandom_range(0, 1) : $urandom_range(0, 2) == 0);
            bus.d_we = $urandom_range(0, 1);
            bus.d_addr = $urandom;
            bus.d_wdata = $urandom;
         end
         if ($urandom_range(0, 59) == 0) no_ack = !no_ack;
         bus.mem_ack = !no_ack && $urandom_range(0, 2) == 0;
         bus.mem_rdata = $urandom;
         @(negedge clk);
         if_done = bus.if_ready;
         d_done = bus.d_ready;
      end
      cyc(); bus.if_req = 0; bus.d_req = 0; bus.mem_ack = 0;
      repeat (20) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
